// File: rtl/xadc_bcd_meter.sv
// ============================================================================
// xadc_bcd_meter : per-channel XADC averaging and U.DDD BCD voltage readout
// Build option XADC_METER_AVG_EN enables averaging.                Rev 1.0
// ============================================================================
`default_nettype none

module xadc_bcd_meter #(
    parameter int NCH           = 4,
    parameter int SEL_W         = 2,
    parameter int AVG_LOG2      = 2,
    parameter int FULL_SCALE_MV = 1000
) (
    input  logic             DCLK,
    input  logic             RESET,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [SEL_W-1:0] s_chan,
    input  logic [15:0]      s_data,
    input  logic [SEL_W-1:0] sel,
    output logic [11:0]      avg_code,
    output logic [15:0]      digits,
    output logic [SEL_W-1:0] digits_chan,
    output logic             digits_valid,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [13:0] FS = 14'(FULL_SCALE_MV);

    state_t           state_q;
    state_t           state_d;
    logic             take;
    logic             chan_ok;
    logic [11:0]      code;
    logic             done_avg;
    logic [11:0]      avg_now;
    logic             pend_valid;
    logic [11:0]      pend_avg;
    logic [SEL_W-1:0] pend_chan;
    logic [11:0]      operand;
    logic [SEL_W-1:0] op_chan;
    logic [25:0]      prod;
    logic [29:0]      sreg;
    logic [29:0]      adj;
    logic [29:0]      dd_next;
    logic [3:0]       step;
    logic             unused_bits;

    assign take    = s_valid && s_ready;
    assign code    = s_data[15:4];
    assign chan_ok = {{(32-SEL_W){1'b0}}, s_chan} < NCH;
    assign s_ready = !pend_valid;
    assign busy    = (state_q != IDLE);
    assign unused_bits = ^{s_data[3:0], prod[11:0]};

`ifdef XADC_METER_AVG_EN
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int AW = 12 + AVG_LOG2;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    logic [AW-1:0] acc [2**SEL_W];
    logic [CW-1:0] cnt [2**SEL_W];
    logic [AW-1:0] sum;

    assign sum      = acc[s_chan] + AW'(code);
    assign avg_now  = sum[AW-1:AVG_LOG2];
    assign done_avg = chan_ok && (cnt[s_chan] == CNT_LAST);

    always_ff @(posedge DCLK) begin
        if (RESET) begin
            for (int i = 0; i < 2**SEL_W; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else if (take && chan_ok) begin
            if (done_avg) begin
                acc[s_chan] <= '0;
                cnt[s_chan] <= '0;
            end else begin
                acc[s_chan] <= sum;
                cnt[s_chan] <= cnt[s_chan] + 1'b1;
            end
        end
    end
`else
    localparam int unused_avg_log2 = AVG_LOG2;

    assign avg_now  = code;
    assign done_avg = chan_ok;
`endif

    // Request capture; s_ready is low whenever the slot is full, so a new
    // request and IDLE consuming the slot never coincide.
    always_ff @(posedge DCLK) begin
        if (RESET) begin
            avg_code   <= '0;
            pend_valid <= 1'b0;
            pend_avg   <= '0;
            pend_chan  <= '0;
        end else begin
            if (take && done_avg) begin
                avg_code <= avg_now;
                if (s_chan == sel) begin
                    pend_valid <= 1'b1;
                    pend_avg   <= avg_now;
                    pend_chan  <= s_chan;
                end
            end
            if (state_q == IDLE && pend_valid) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge DCLK) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pend_valid) state_d = MUL;
            MUL:     state_d = SHIFT;
            SHIFT:   if (step == 4'd13) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign prod = {14'd0, operand} * {12'd0, FS};

    // Double-dabble step: BCD nibbles sit above the 14-bit binary field.
    always_comb begin
        adj = sreg;
        for (int n = 0; n < 4; n++) begin
            if (adj[14+4*n +: 4] >= 4'd5) adj[14+4*n +: 4] = adj[14+4*n +: 4] + 4'd3;
        end
        dd_next = {adj[28:0], 1'b0};
    end

    always_ff @(posedge DCLK) begin
        if (RESET) begin
            operand      <= '0;
            op_chan      <= '0;
            sreg         <= '0;
            step         <= '0;
            digits       <= '0;
            digits_chan  <= '0;
            digits_valid <= 1'b0;
        end else begin
            digits_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pend_valid) begin
                        operand <= pend_avg;
                        op_chan <= pend_chan;
                    end
                end
                MUL: begin
                    sreg <= {16'd0, prod[25:12]};
                    step <= '0;
                end
                SHIFT: begin
                    sreg <= dd_next;
                    step <= step + 4'd1;
                end
                DONE: begin
                    digits       <= sreg[29:14];
                    digits_chan  <= op_chan;
                    digits_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_xadc_bcd_meter.sv
// ============================================================================
// tb_xadc_bcd_meter : directed self-checking bench for xadc_bcd_meter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_xadc_bcd_meter;

`ifdef XADC_METER_AVG_EN
    localparam int REP = 4;
`else
    localparam int REP = 1;
`endif

    logic        DCLK = 1'b0;
    logic        RESET = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [1:0]  s_chan = 2'd0;
    logic [15:0] s_data = 16'd0;
    logic [1:0]  sel = 2'd0;
    logic [11:0] avg_code;
    logic [15:0] digits;
    logic [1:0]  digits_chan;
    logic        digits_valid;
    logic        busy;

    xadc_bcd_meter #(
        .NCH(4), .SEL_W(2), .AVG_LOG2(2), .FULL_SCALE_MV(1000)
    ) dut (
        .DCLK(DCLK), .RESET(RESET), .s_valid(s_valid), .s_ready(s_ready),
        .s_chan(s_chan), .s_data(s_data), .sel(sel), .avg_code(avg_code),
        .digits(digits), .digits_chan(digits_chan), .digits_valid(digits_valid),
        .busy(busy)
    );

    always #5 DCLK = ~DCLK;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int dbl = 0;
    int acc_cyc = 0;
    logic prev_dv = 1'b0;
    int p_cyc[$];
    logic [15:0] p_dig[$];
    logic [1:0] p_ch[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Records every digits_valid pulse with its edge number.
    always @(posedge DCLK) begin
        cyc++;
        #1;
        if (digits_valid) begin
            p_cyc.push_back(cyc);
            p_dig.push_back(digits);
            p_ch.push_back(digits_chan);
            if (prev_dv) dbl++;
        end
        prev_dv = digits_valid;
    end

    task automatic send1(input logic [1:0] ch, input logic [15:0] d);
        int w;
        @(negedge DCLK);
        s_valid = 1'b1;
        s_chan  = ch;
        s_data  = d;
        w = 0;
        while (!s_ready && w < 200) begin
            @(negedge DCLK);
            w++;
        end
        chk("send_ready", 32'(s_ready), 32'd1);
        @(posedge DCLK);
        #1;
        s_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic send(input logic [1:0] ch, input logic [15:0] d);
        repeat (REP) send1(ch, d);
    endtask

    task automatic wait_pulses(input int n);
        int w;
        w = 0;
        while (p_cyc.size() < n && w < 500) begin
            @(negedge DCLK);
            w++;
        end
        chk("pulse_count", 32'(p_cyc.size()), 32'(n));
    endtask

    initial begin
        int a3;
        repeat (3) @(negedge DCLK);
        RESET = 1'b0;
        @(negedge DCLK);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_avg_code", 32'(avg_code), 32'd0);
        chk("rst_digits", 32'(digits), 32'd0);
        chk("rst_digits_chan", 32'(digits_chan), 32'd0);
        chk("rst_digits_valid", 32'(digits_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Basic conversion and latency
        sel = 2'd0;
        send(2'd0, 16'hE3E0);
        chk("t2_avg_code", 32'(avg_code), 32'h0E3E);
        chk("t2_ready_low", 32'(s_ready), 32'd0);
        wait_pulses(1);
        chk("t2_latency", 32'(p_cyc[0] - acc_cyc), 32'd17);
        chk("t2_digits", 32'(p_dig[0]), 32'h0890);
        chk("t2_chan", 32'(p_ch[0]), 32'd0);

        // Boundary codes
        send(2'd0, 16'h0000);
        wait_pulses(2);
        chk("zero_digits", 32'(p_dig[1]), 32'h0000);
        send(2'd0, 16'hFFF0);
        wait_pulses(3);
        chk("full_digits", 32'(p_dig[2]), 32'h0999);
        chk("full_out", 32'(digits), 32'h0999);

        // Back-to-back requests while busy
        send(2'd0, 16'h8000);
        send(2'd0, 16'h4000);
        chk("b2b_ready_low", 32'(s_ready), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        send(2'd0, 16'h1230);
        a3 = acc_cyc;
        wait_pulses(6);
        chk("b2b_dig1", 32'(p_dig[3]), 32'h0500);
        chk("b2b_dig2", 32'(p_dig[4]), 32'h0250);
        chk("b2b_dig3", 32'(p_dig[5]), 32'h0071);
        chk("b2b_space12", 32'(p_cyc[4] - p_cyc[3]), 32'd17);
        chk("b2b_space23", 32'(p_cyc[5] - p_cyc[4]), 32'd17);
        chk("b2b_third_stalled", 32'(a3 > p_cyc[3]), 32'd1);

        // Interleaved channels, only sel converts
        sel = 2'd2;
        send(2'd0, 16'h5550);
        chk("il_avg_c0", 32'(avg_code), 32'h0555);
        send(2'd2, 16'hC000);
        chk("il_avg_c2", 32'(avg_code), 32'h0C00);
        wait_pulses(7);
        repeat (20) @(negedge DCLK);
        chk("il_pulses", 32'(p_cyc.size()), 32'd7);
        chk("il_chan", 32'(p_ch[6]), 32'd2);
        chk("il_digits", 32'(p_dig[6]), 32'h0750);

        // sel change while a conversion is shifting and another is pending
        sel = 2'd0;
        send(2'd0, 16'h2000);
        send(2'd0, 16'h1000);
        repeat (3) @(negedge DCLK);
        sel = 2'd3;
        send(2'd3, 16'hE3E0);
        wait_pulses(10);
        chk("sel_ch1", 32'(p_ch[7]), 32'd0);
        chk("sel_dig1", 32'(p_dig[7]), 32'h0125);
        chk("sel_ch2", 32'(p_ch[8]), 32'd0);
        chk("sel_dig2", 32'(p_dig[8]), 32'h0062);
        chk("sel_ch3", 32'(p_ch[9]), 32'd3);
        chk("sel_dig3", 32'(p_dig[9]), 32'h0890);

        // Reset in the middle of SHIFT, with a partial chan-1 average
        sel = 2'd0;
        send1(2'd1, 16'hFFF0);
        send(2'd0, 16'hFFF0);
        repeat (8) @(negedge DCLK);
        chk("mid_busy", 32'(busy), 32'd1);
        RESET = 1'b1;
        @(negedge DCLK);
        RESET = 1'b0;
        chk("mr_s_ready", 32'(s_ready), 32'd1);
        chk("mr_avg_code", 32'(avg_code), 32'd0);
        chk("mr_digits", 32'(digits), 32'd0);
        chk("mr_digits_chan", 32'(digits_chan), 32'd0);
        chk("mr_digits_valid", 32'(digits_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        repeat (30) @(negedge DCLK);
        chk("mr_no_pulse", 32'(p_cyc.size()), 32'd10);

        // Four distinct codes on chan 1
        sel = 2'd1;
        send1(2'd1, 16'h0640);
        send1(2'd1, 16'h0C80);
        send1(2'd1, 16'h12C0);
        send1(2'd1, 16'h1900);
`ifdef XADC_METER_AVG_EN
        wait_pulses(11);
        chk("avg_code", 32'(avg_code), 32'd250);
        chk("avg_digits", 32'(p_dig[10]), 32'h0061);
`else
        wait_pulses(14);
        chk("avg_code", 32'(avg_code), 32'd400);
        chk("avg_digits", 32'(p_dig[13]), 32'h0097);
`endif
        chk("avg_chan", 32'(digits_chan), 32'd1);
        chk("single_cycle_pulses", 32'(dbl), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
